fifo_dedup_writer: RTL

//  Upstream write front-end for the dedup FIFO (check_req/check_dat -> check_res/check_vld port).

---
 rtl/fifo_dedup_writer_pkg.sv | 29 ++
 rtl/fifo_dedup_writer_sat_counter.sv | 39 +++
 rtl/fifo_dedup_writer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fifo_dedup_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_dedup_writer_pkg
// Brief  : State encoding and saturating-increment helper for the dedup writer.
// Rev    : 1.0  initial release
// ============================================================================
package fifo_dedup_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DROP  = 3'd5
  } state_e;

  localparam int unsigned SAT_MAX_W = 64;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                   input int unsigned width);
    logic [SAT_MAX_W-1:0] max_val;
    max_val = (width >= SAT_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? val : val + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_dedup_writer_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Statistics counter that increments on inc_i and saturates at all-ones.
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter
  import fifo_dedup_writer_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = CNT_WIDTH'(sat_inc(SAT_MAX_W'(cnt_q), unsigned'(CNT_WIDTH)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fifo_dedup_writer.sv
`default_nettype none
// ============================================================================
// Module : fifo_dedup_writer
// Brief  : Write front-end that searches the FIFO and writes only unseen words.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_dedup_writer
  import fifo_dedup_writer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld_i,
  input  logic [DATA_WIDTH-1:0] in_dat_i,
  output logic                  in_rdy_o,
  input  logic                  fifo_full_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_wren_o,
  output logic [DATA_WIDTH-1:0] fifo_wdat_o,
  output logic                  check_req_o,
  output logic [DATA_WIDTH-1:0] check_dat_o,
  input  logic                  check_res_i,
  input  logic                  check_vld_i,
  output logic                  drop_pulse_o,
  output logic [CNT_WIDTH-1:0]  wr_cnt_o,
  output logic [CNT_WIDTH-1:0]  drop_cnt_o,
  output logic                  timeout_err_o
);

  localparam int               TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    retry_q, retry_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    tmo_err_q, tmo_err_d;
  logic                    in_rdy_q;
  logic                    wren_q, wren_d;
  logic                    req_q, req_d;
  logic                    drop_q, drop_d;

  always_comb begin
    state_d   = state_q;
    dat_d     = dat_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    tmo_err_d = tmo_err_q;
    wren_d    = 1'b0;
    req_d     = 1'b0;
    drop_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_vld_i) begin
          dat_d   = in_dat_i;
          retry_d = 1'b0;
          state_d = fifo_empty_i ? ST_WRITE : ST_REQ;
        end
      end
      ST_REQ: begin
        req_d   = 1'b1;
        tmo_d   = '0;
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        // A completion here may belong to the stale compare register: re-issue once.
        tmo_d = tmo_q + 1'b1;
        if (check_vld_i && !retry_q) begin
          retry_d = 1'b1;
          state_d = ST_REQ;
        end else if (check_vld_i) begin
          state_d = check_res_i ? ST_DROP : ST_WRITE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (check_vld_i) begin
          state_d = check_res_i ? ST_DROP : ST_WRITE;
        end else if (tmo_q == TMO_LAST) begin
          // Fail open: an unanswered search still writes the word.
          tmo_err_d = 1'b1;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!fifo_full_i) begin
          wren_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        drop_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dat_q     <= '0;
      retry_q   <= 1'b0;
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
      in_rdy_q  <= 1'b1;
      wren_q    <= 1'b0;
      req_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dat_q     <= dat_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
      in_rdy_q  <= (state_d == ST_IDLE);
      wren_q    <= wren_d;
      req_q     <= req_d;
      drop_q    <= drop_d;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wren_d),
    .cnt_o (wr_cnt_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (drop_d),
    .cnt_o (drop_cnt_o)
  );

  assign in_rdy_o      = in_rdy_q;
  assign fifo_wren_o   = wren_q;
  assign fifo_wdat_o   = dat_q;
  assign check_req_o   = req_q;
  assign check_dat_o   = dat_q;
  assign drop_pulse_o  = drop_q;
  assign timeout_err_o = tmo_err_q;

endmodule
`default_nettype wire
